// File: rtl/bcd_counter_00_99_ctrl.sv
// bcd_counter_00_99_ctrl: debounced push-button BCD 00-99 up/down counter stepped by tick_in.
// Define SAT_STOP_EN to saturate at the range ends and pause instead of wrapping.
module bcd_counter_00_99_ctrl #(
   parameter int DEB_CYCLES = 200000,
   parameter int CNT_W = 18
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick_in,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       btn_pause,
   input  logic       btn_clr,
   output logic [3:0] tens,
   output logic [3:0] units,
   output logic [1:0] mode,
   output logic       wrap
);
   typedef enum logic [1:0] {PAUSE = 2'b00, UP = 2'b01, DOWN = 2'b10} state_t;
   state_t state, state_nx, dir, dir_nx;
   logic [3:0] btn_s1, btn_s2, deb, deb_q, press;
   logic [CNT_W-1:0] cnt [4];
   logic [3:0] tens_nx, units_nx;
   logic wrap_nx;
   // button index: 0 up, 1 down, 2 pause, 3 clr
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         btn_s1 <= '0;
         btn_s2 <= '0;
         deb <= '0;
         deb_q <= '0;
         for (int k = 0; k < 4; k++) cnt[k] <= '0;
      end else begin
         btn_s1 <= {btn_clr, btn_pause, btn_down, btn_up};
         btn_s2 <= btn_s1;
         deb_q <= deb;
         for (int k = 0; k < 4; k++) begin
            if (btn_s2[k] == deb[k]) cnt[k] <= '0;
            else if (cnt[k] == CNT_W'(DEB_CYCLES - 1)) begin
               deb[k] <= btn_s2[k];
               cnt[k] <= '0;
            end else cnt[k] <= cnt[k] + CNT_W'(1);
         end
      end
   end
   assign press = deb & ~deb_q;
   assign mode = state;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= UP;
         dir <= UP;
         tens <= 4'd0;
         units <= 4'd0;
         wrap <= 1'b0;
      end else begin
         state <= state_nx;
         dir <= dir_nx;
         tens <= tens_nx;
         units <= units_nx;
         wrap <= wrap_nx;
      end
   end
   // the step uses the registered state; same-cycle events are layered on top, clear overriding the step
   always_comb begin
      state_nx = state;
      dir_nx = dir;
      tens_nx = tens;
      units_nx = units;
      wrap_nx = 1'b0;
      if (tick_in && !press[3] && state == UP) begin
         if (tens == 4'd9 && units == 4'd9) begin
            wrap_nx = 1'b1;
`ifdef SAT_STOP_EN
            state_nx = PAUSE;
            dir_nx = UP;
`else
            tens_nx = 4'd0;
            units_nx = 4'd0;
`endif
         end else begin
            units_nx = (units == 4'd9) ? 4'd0 : units + 4'd1;
            tens_nx = (units == 4'd9) ? tens + 4'd1 : tens;
         end
      end
      if (tick_in && !press[3] && state == DOWN) begin
         if (tens == 4'd0 && units == 4'd0) begin
            wrap_nx = 1'b1;
`ifdef SAT_STOP_EN
            state_nx = PAUSE;
            dir_nx = DOWN;
`else
            tens_nx = 4'd9;
            units_nx = 4'd9;
`endif
         end else begin
            units_nx = (units == 4'd0) ? 4'd9 : units - 4'd1;
            tens_nx = (units == 4'd0) ? tens - 4'd1 : tens;
         end
      end
      if (press[3]) begin
         tens_nx = 4'd0;
         units_nx = 4'd0;
      end
      if (press[2]) begin
         state_nx = (state == PAUSE) ? dir : PAUSE;
         dir_nx = (state == PAUSE) ? dir : state;
      end else if (press[0]) begin
         state_nx = UP;
         dir_nx = UP;
      end else if (press[1]) begin
         state_nx = DOWN;
         dir_nx = DOWN;
      end
   end
endmodule

// File: tb/tb_bcd_counter_00_99_ctrl.sv
// tb_bcd_counter_00_99_ctrl: randomized and directed bench against a decimal-value reference model.
module tb_bcd_counter_00_99_ctrl;
   localparam int DEB = 4;
   logic clk = 1'b0;
   logic rst = 1'b0;
   logic tick_in = 1'b0;
   logic btn_up = 1'b0;
   logic btn_down = 1'b0;
   logic btn_pause = 1'b0;
   logic btn_clr = 1'b0;
   logic [3:0] tens, units;
   logic [1:0] mode;
   logic wrap;
   int checks = 0;
   int errors = 0;
   int m_val, m_mode, m_dir;
   logic m_wrap;

   bcd_counter_00_99_ctrl #(.DEB_CYCLES(DEB), .CNT_W(4)) dut (
      .clk(clk), .rst(rst), .tick_in(tick_in), .btn_up(btn_up), .btn_down(btn_down),
      .btn_pause(btn_pause), .btn_clr(btn_clr), .tens(tens), .units(units), .mode(mode), .wrap(wrap)
   );

   always #5 clk = ~clk;

   // model: count held as a plain 0..99 integer, mode 0 pause / 1 up / 2 down
   function automatic void model_reset();
      m_val = 0;
      m_mode = 1;
      m_dir = 1;
      m_wrap = 1'b0;
   endfunction

   function automatic void model_tick();
      m_wrap = 1'b0;
      if (m_mode == 1) begin
         if (m_val == 99) begin
            m_wrap = 1'b1;
`ifdef SAT_STOP_EN
            m_mode = 0;
            m_dir = 1;
`else
            m_val = 0;
`endif
         end else m_val++;
      end else if (m_mode == 2) begin
         if (m_val == 0) begin
            m_wrap = 1'b1;
`ifdef SAT_STOP_EN
            m_mode = 0;
            m_dir = 2;
`else
            m_val = 99;
`endif
         end else m_val--;
      end
   endfunction

   function automatic void model_events(input logic [3:0] mask);
      if (mask[3]) m_val = 0;
      if (mask[2]) begin
         if (m_mode == 0) m_mode = m_dir;
         else begin
            m_dir = m_mode;
            m_mode = 0;
         end
      end else if (mask[0]) begin
         m_mode = 1;
         m_dir = 1;
      end else if (mask[1]) begin
         m_mode = 2;
         m_dir = 2;
      end
   endfunction

   function automatic logic [10:0] exp_vec();
      return {4'(m_val / 10), 4'(m_val % 10), 2'(m_mode), m_wrap};
   endfunction

   task automatic cycle(input bit tk);
      tick_in = tk;
      @(posedge clk);
      #1;
      tick_in = 1'b0;
      if (tk) model_tick();
      else m_wrap = 1'b0;
   endtask

   // clean press of the buttons in mask {clr,pause,down,up}; optional tick on the event cycle
   task automatic press(input logic [3:0] mask, input bit tk, output logic [10:0] got, output logic [10:0] exp);
      {btn_clr, btn_pause, btn_down, btn_up} = mask;
      repeat (DEB + 2) cycle(1'b0);
      tick_in = tk;
      @(posedge clk);
      #1;
      tick_in = 1'b0;
      m_wrap = 1'b0;
      if (tk && !mask[3]) model_tick();
      model_events(mask);
      got = {tens, units, mode, wrap};
      exp = exp_vec();
      {btn_clr, btn_pause, btn_down, btn_up} = 4'b0000;
      repeat (DEB + 6) cycle(1'b0);
   endtask

   task automatic test_reset();
      model_reset();
      repeat (3) cycle(1'b0);
      if ({tens, units, mode, wrap} !== 11'b0000_0000_01_0) begin
         errors++;
         $display("FAIL reset_state got %h expected %h", {tens, units, mode, wrap}, 11'b0000_0000_01_0);
      end
      checks++;
      rst = 1'b1;
      cycle(1'b0);
   endtask

   task automatic test_count_up();
      repeat (12) begin
         cycle(1'b1);
         repeat (4) cycle(1'b0);
      end
      if ({tens, units, mode, wrap} !== exp_vec() || exp_vec() !== 11'b0001_0010_01_0) begin
         errors++;
         $display("FAIL count_12 got %h expected %h", {tens, units, mode, wrap}, exp_vec());
      end
      checks++;
      cycle(1'b1);
      cycle(1'b1);
      #3;
      rst = 1'b0;
      #1;
      model_reset();
      if ({tens, units, mode, wrap} !== exp_vec()) begin
         errors++;
         $display("FAIL async_reset got %h expected %h", {tens, units, mode, wrap}, exp_vec());
      end
      checks++;
      repeat (2) cycle(1'b0);
      rst = 1'b1;
      cycle(1'b1);
      if ({tens, units, mode, wrap} !== exp_vec()) begin
         errors++;
         $display("FAIL first_tick_after_reset got %h expected %h", {tens, units, mode, wrap}, exp_vec());
      end
      checks++;
   endtask

   task automatic test_wrap();
      logic [10:0] g, e;
      press(4'b1001, 1'b0, g, e);
      repeat (98) cycle(1'b1);
      for (int i = 0; i < 4; i++) begin
         cycle(i < 2);
         if ({tens, units, mode, wrap} !== exp_vec()) begin
            errors++;
            $display("FAIL wrap_up step %0d got %h expected %h", i, {tens, units, mode, wrap}, exp_vec());
         end
         checks++;
      end
      cycle(1'b1);
      press(4'b0010, 1'b0, g, e);
      for (int i = 0; i < 4; i++) begin
         cycle(i < 2);
         if ({tens, units, mode, wrap} !== exp_vec()) begin
            errors++;
            $display("FAIL wrap_down step %0d got %h expected %h", i, {tens, units, mode, wrap}, exp_vec());
         end
         checks++;
      end
   endtask

   task automatic test_bounce();
      logic [10:0] g, e;
      press(4'b0001, 1'b0, g, e);
      for (int i = 0; i < 2; i++) begin
         btn_down = 1'b1;
         repeat (2) cycle(1'b0);
         btn_down = 1'b0;
         for (int j = 0; j < 2; j++) begin
            cycle(1'b0);
            if (mode !== 2'b01) begin
               errors++;
               $display("FAIL bounce_no_event got %b expected %b", mode, 2'b01);
            end
            checks++;
         end
      end
      btn_down = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         cycle(1'b0);
         if (mode !== ((k >= DEB + 3) ? 2'b10 : 2'b01)) begin
            errors++;
            $display("FAIL bounce_latency cycle %0d got %b expected %b", k, mode, (k >= DEB + 3) ? 2'b10 : 2'b01);
         end
         checks++;
      end
      model_events(4'b0010);
      btn_down = 1'b0;
      repeat (DEB + 6) cycle(1'b0);
      if ({tens, units, mode, wrap} !== exp_vec()) begin
         errors++;
         $display("FAIL bounce_release got %h expected %h", {tens, units, mode, wrap}, exp_vec());
      end
      checks++;
   endtask

   task automatic test_pause();
      logic [10:0] g, e;
      press(4'b1001, 1'b0, g, e);
      repeat (37) begin
         cycle(1'b1);
         repeat (4) cycle(1'b0);
      end
      press(4'b0100, 1'b0, g, e);
      if (g !== e || mode !== 2'b00) begin
         errors++;
         $display("FAIL pause_enter got %h expected %h", g, e);
      end
      checks++;
      repeat (5) begin
         cycle(1'b1);
         repeat (4) cycle(1'b0);
      end
      if ({tens, units, mode, wrap} !== exp_vec()) begin
         errors++;
         $display("FAIL pause_hold got %h expected %h", {tens, units, mode, wrap}, exp_vec());
      end
      checks++;
      press(4'b0100, 1'b0, g, e);
      if (g !== e) begin
         errors++;
         $display("FAIL pause_resume got %h expected %h", g, e);
      end
      checks++;
      cycle(1'b1);
      if ({tens, units, mode, wrap} !== exp_vec()) begin
         errors++;
         $display("FAIL resume_tick got %h expected %h", {tens, units, mode, wrap}, exp_vec());
      end
      checks++;
   endtask

   task automatic test_clr_down_tick();
      logic [10:0] g, e;
      press(4'b1001, 1'b0, g, e);
      repeat (45) cycle(1'b1);
      press(4'b1010, 1'b1, g, e);
      if (g !== e) begin
         errors++;
         $display("FAIL clr_down_tick got %h expected %h", g, e);
      end
      checks++;
      for (int i = 0; i < 2; i++) begin
         cycle(i == 0);
         if ({tens, units, mode, wrap} !== exp_vec()) begin
            errors++;
            $display("FAIL after_clr step %0d got %h expected %h", i, {tens, units, mode, wrap}, exp_vec());
         end
         checks++;
      end
   endtask

   task automatic test_sat();
      logic [10:0] g, e;
      press(4'b1001, 1'b0, g, e);
      repeat (99) cycle(1'b1);
      for (int i = 0; i < 2; i++) begin
         cycle(i == 0);
         if ({tens, units, mode, wrap} !== exp_vec()) begin
            errors++;
            $display("FAIL top_end step %0d got %h expected %h", i, {tens, units, mode, wrap}, exp_vec());
         end
         checks++;
      end
      press(4'b0100, 1'b0, g, e);
      if (g !== e) begin
         errors++;
         $display("FAIL top_pause got %h expected %h", g, e);
      end
      checks++;
      cycle(1'b1);
      if ({tens, units, mode, wrap} !== exp_vec()) begin
         errors++;
         $display("FAIL top_retick got %h expected %h", {tens, units, mode, wrap}, exp_vec());
      end
      checks++;
   endtask

   task automatic test_random();
      logic [10:0] g, e;
      int n, gap;
      for (int it = 0; it < 40; it++) begin
         if ($urandom_range(0, 2) != 0) begin
            n = $urandom_range(1, 40);
            gap = $urandom_range(1, 4);
            repeat (n) begin
               for (int j = 0; j < gap; j++) begin
                  cycle(j == 0);
                  if ({tens, units, mode, wrap} !== exp_vec()) begin
                     errors++;
                     $display("FAIL random_tick iter %0d got %h expected %h", it, {tens, units, mode, wrap}, exp_vec());
                  end
                  checks++;
               end
            end
         end else begin
            press(4'($urandom_range(1, 15)), 1'($urandom_range(0, 1)), g, e);
            if (g !== e) begin
               errors++;
               $display("FAIL random_event iter %0d got %h expected %h", it, g, e);
            end
            checks++;
         end
      end
   endtask

   initial begin
      test_reset();
      test_count_up();
      test_wrap();
      test_bounce();
      test_pause();
      test_clr_down_tick();
      test_sat();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
